// File: rtl/noc_arb_mux_if.sv
// Channel bundle for noc_arb_mux: NUM_IN valid/ready inputs, mode controls
// and one registered valid/ready output.
interface noc_arb_mux_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN-1:0]            in_ready;
  logic                         rr_en;
  logic [SEL_W-1:0]             sel;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [SEL_W-1:0]             out_src;

  modport slave (
    input  in_data, in_valid, rr_en, sel, out_ready,
    output in_ready, out_data, out_valid, out_src
  );

  modport master (
    output in_data, in_valid, rr_en, sel, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/noc_arb_mux.sv
// Registered N:1 valid/ready channel mux with static-select or round-robin
// arbitration; one output register, one cycle latency, full throughput.
module noc_arb_mux #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 4
) (
  input  logic         clk,
  input  logic         reset,
  noc_arb_mux_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_src_q, out_src_d;
  logic                  out_valid_q, out_valid_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;

  logic [NUM_IN-1:0]     grant;
  logic [SEL_W-1:0]      grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  grant_any;
  logic                  can_load;
  logic                  xfer;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the loops below can leave a signal unassigned (latch).
    grant      = '0;
    grant_idx  = '0;
    grant_data = '0;
    grant_any  = 1'b0;

    if (!bus.rr_en) begin
      // An out-of-range sel matches no channel and therefore grants nothing.
      for (int i = 0; i < NUM_IN; i++) begin
        if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
          grant_idx = SEL_W'(i);
          grant_any = 1'b1;
        end
      end
    end else begin
      // Scan channels above the pointer first, then wrap to 0..ptr.
      for (int i = 0; i < NUM_IN; i++) begin
        if (!grant_any && i > int'(ptr_q) && bus.in_valid[i]) begin
          grant_idx = SEL_W'(i);
          grant_any = 1'b1;
        end
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (!grant_any && i <= int'(ptr_q) && bus.in_valid[i]) begin
          grant_idx = SEL_W'(i);
          grant_any = 1'b1;
        end
      end
    end

    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_any && grant_idx == SEL_W'(i)) begin
        grant[i]   = 1'b1;
        grant_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A word being drained this cycle frees the slot for a same-cycle load.
  assign can_load     = !out_valid_q || bus.out_ready;
  assign xfer         = grant_any && can_load && !reset;
  assign bus.in_ready = (can_load && !reset) ? grant : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_src_d   = grant_idx;
      // Pointer follows every accepted word, in either mode.
      ptr_d       = grant_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= SEL_W'(NUM_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_noc_arb_mux.sv
// Scoreboard bench for noc_arb_mux: directed grants push expected words,
// a monitor pops and compares on every output handshake.
module tb_noc_arb_mux;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst3;

  noc_arb_mux_if #(.DATA_WIDTH(DW), .NUM_IN(4)) b4 ();
  noc_arb_mux_if #(.DATA_WIDTH(DW), .NUM_IN(3)) b3 ();

  noc_arb_mux #(.DATA_WIDTH(DW), .NUM_IN(4)) dut4 (
    .clk   (clk),
    .reset (rst4),
    .bus   (b4.slave)
  );

  noc_arb_mux #(.DATA_WIDTH(DW), .NUM_IN(3)) dut3 (
    .clk   (clk),
    .reset (rst3),
    .bus   (b3.slave)
  );

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } word_t;

  word_t q4[$];
  word_t q3[$];

  logic [DW-1:0] base4, base3;
  int passed = 0;
  int total  = 0;

  always_comb for (int i = 0; i < 4; i++) b4.in_data[i*DW +: DW] = base4 + DW'(i);
  always_comb for (int i = 0; i < 3; i++) b3.in_data[i*DW +: DW] = base3 + DW'(i);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // One clock cycle: check in_ready against the hand-computed grant and,
  // if a transfer is expected, queue the word that must come out.
  task automatic step(input int dut, input logic [3:0] exp_rdy, input string nm);
    word_t w;
    @(negedge clk);
    if (dut == 4) check(nm, 32'(b4.in_ready), 32'(exp_rdy));
    else          check(nm, 32'(b3.in_ready), 32'(exp_rdy[2:0]));
    if (exp_rdy != 4'b0000) begin
      w.src = 2'd0;
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) w.src = 2'(i);
      w.data = ((dut == 4) ? base4 : base3) + DW'(w.src);
      if (dut == 4) q4.push_back(w);
      else          q3.push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    word_t w;
    forever begin
      @(negedge clk);
      if (!rst4 && b4.out_valid && b4.out_ready) begin
        if (q4.size() == 0) check("sb4_unexpected_word", 32'(q4.size()), 32'd1);
        else begin
          w = q4.pop_front();
          check("sb4_data", 32'(b4.out_data), 32'(w.data));
          check("sb4_src", 32'(b4.out_src), 32'(w.src));
        end
      end
      if (!rst3 && b3.out_valid && b3.out_ready) begin
        if (q3.size() == 0) check("sb3_unexpected_word", 32'(q3.size()), 32'd1);
        else begin
          w = q3.pop_front();
          check("sb3_data", 32'(b3.out_data), 32'(w.data));
          check("sb3_src", 32'(b3.out_src), 32'(w.src));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst4 = 1'b1; rst3 = 1'b1;
    base4 = 16'h00A0; base3 = 16'h0300;
    b4.rr_en = 1'b0; b4.sel = 2'd2; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
    b3.rr_en = 1'b0; b3.sel = 2'd2; b3.in_valid = 3'b000;  b3.out_ready = 1'b1;

    // Reset state
    step(4, 4'b0000, "reset_in_ready");
    check("reset_out_valid", 32'(b4.out_valid), 32'd0);
    check("reset_out_data", 32'(b4.out_data), 32'd0);
    check("reset_out_src", 32'(b4.out_src), 32'd0);
    rst4 = 1'b0;

    // Static select of channel 2
    for (int k = 0; k < 4; k++) step(4, 4'b0100, "static_sel2");
    check("static_out_data", 32'(b4.out_data), 32'h00A2);
    check("static_out_src", 32'(b4.out_src), 32'd2);
    b4.in_valid = 4'b0000;
    step(4, 4'b0000, "idle");
    rst4 = 1'b1;
    step(4, 4'b0000, "reset2_in_ready");
    rst4 = 1'b0;

    // Round-robin fairness from reset
    b4.rr_en = 1'b1; b4.in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) step(4, 4'(1 << (k % 4)), "rr_fair");

    // Sparse round-robin, then single requester
    b4.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) step(4, (k % 2 == 0) ? 4'b0010 : 4'b1000, "rr_sparse");
    b4.in_valid = 4'b0010;
    for (int k = 0; k < 3; k++) step(4, 4'b0010, "rr_single");

    // Back-pressure: grant 2, stall three cycles, then successor 3
    b4.in_valid = 4'b1111;
    step(4, 4'b0100, "bp_load");
    b4.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(4, 4'b0000, "bp_stall_in_ready");
      check("bp_out_valid", 32'(b4.out_valid), 32'd1);
      check("bp_out_data", 32'(b4.out_data), 32'h00A2);
      check("bp_out_src", 32'(b4.out_src), 32'd2);
    end
    b4.out_ready = 1'b1;
    step(4, 4'b1000, "bp_release_successor");

    // Mode switch: rr grant 1, static sel=3, back to rr -> 0
    b4.in_valid = 4'b0010;
    step(4, 4'b0010, "mode_rr_grant1");
    b4.in_valid = 4'b1111; b4.rr_en = 1'b0; b4.sel = 2'd3;
    step(4, 4'b1000, "mode_static_sel3");
    b4.rr_en = 1'b1;
    step(4, 4'b0001, "mode_rr_after_static");
    b4.rr_en = 1'b0; b4.sel = 2'd2; b4.in_valid = 4'b1011;
    step(4, 4'b0000, "static_sel_not_valid");
    check("drain_out_valid", 32'(b4.out_valid), 32'd0);

    // Reset while a word is held
    b4.rr_en = 1'b1; b4.in_valid = 4'b1111;
    step(4, 4'b0010, "pre_reset_grant");
    b4.out_ready = 1'b0; rst4 = 1'b1;
    step(4, 4'b0000, "midreset_in_ready");
    q4.delete();
    check("midreset_out_valid", 32'(b4.out_valid), 32'd0);
    check("midreset_out_data", 32'(b4.out_data), 32'd0);
    rst4 = 1'b0; b4.out_ready = 1'b1;
    step(4, 4'b0001, "post_reset_first_grant");
    b4.in_valid = 4'b0000;
    step(4, 4'b0000, "dut4_idle");

    // NUM_IN=3: illegal sel, then wrap-around round-robin
    rst3 = 1'b0; b3.in_valid = 3'b111; b3.sel = 2'd2;
    step(3, 4'b0100, "n3_static_sel2");
    b3.sel = 2'd3;
    step(3, 4'b0000, "n3_illegal_sel");
    check("n3_drain_out_valid", 32'(b3.out_valid), 32'd0);
    step(3, 4'b0000, "n3_illegal_sel_hold");
    check("n3_still_empty", 32'(b3.out_valid), 32'd0);
    b3.rr_en = 1'b1;
    step(3, 4'b0001, "n3_rr");
    step(3, 4'b0010, "n3_rr");
    step(3, 4'b0100, "n3_rr");
    step(3, 4'b0001, "n3_rr_wrap");
    b3.in_valid = 3'b000;
    step(3, 4'b0000, "n3_idle");

    repeat (3) @(posedge clk);
    #1;
    check("sb4_queue_drained", 32'(q4.size()), 32'd0);
    check("sb3_queue_drained", 32'(q3.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
